// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
// State encoding, bus widths, error codes and an alignment helper.
package dmem_access_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE,
        DONE
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE       = 2'd0;
    localparam err_code_t ERR_TIMEOUT    = 2'd1;
    localparam err_code_t ERR_MISALIGNED = 2'd2;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory side bus: controller drives address/data/strobe,
// memory returns read data and a ready level.
interface dmem_access_ctrl_if;
    import dmem_access_ctrl_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/dmem_access_ctrl_sat_counter.sv
// Up-counter that sticks at LIMIT instead of wrapping.
// Synchronous clear wins over enable.
module dmem_access_ctrl_sat_counter #(
    parameter int W     = 5,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != W'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage initiator for the data-memory ready handshake.
// Holds address/data stable, waits for ready, stalls the pipeline.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int TIMEOUT       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              err_timeout,
    output logic              err_misaligned,
    dmem_access_ctrl_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_to_q, err_to_d;
    logic              err_mis_q, err_mis_d;
    logic              op_wr_q, op_wr_d;
    logic [CNT_W-1:0]  cnt;

    logic req_any;
    logic aligned;
    logic proceed;
    logic timed_out;

    assign req_any   = req_read | req_write;
    assign aligned   = is_aligned(req_addr[1:0]);
    // Ready is ignored until the stale level from the old address has settled.
    assign proceed   = (cnt >= CNT_W'(SETTLE_CYCLES)) && mem.mem_ready;
    assign timed_out = (cnt == CNT_W'(TIMEOUT)) && !proceed;

    dmem_access_ctrl_sat_counter #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == IDLE),
        .en    (state_q == WAIT),
        .count (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            err_to_q    <= 1'b0;
            err_mis_q   <= 1'b0;
            op_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            err_to_q    <= err_to_d;
            err_mis_q   <= err_mis_d;
            op_wr_q     <= op_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = aligned ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (proceed) begin
                    state_d = op_wr_q ? WRITE : DONE;
                end else if (timed_out) begin
                    state_d = DONE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rdata_d     = rdata_q;
        err_to_d    = err_to_q;
        err_mis_d   = err_mis_q;
        op_wr_d     = op_wr_q;
        unique case (state_q)
            IDLE: begin
                if (req_any && aligned) begin
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    op_wr_d     = req_write;
                end else if (req_any) begin
                    err_mis_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            WAIT: begin
                // Strobe is registered so it is high exactly in WRITE.
                if (proceed && op_wr_q) begin
                    mem_we_d = 1'b1;
                end else if (proceed) begin
                    rdata_d = mem.mem_rdata;
                end else if (timed_out) begin
                    err_to_d = 1'b1;
                    rdata_d  = '0;
                end
            end
            default: ;
        endcase
    end

    assign stall          = req_any && (state_q != DONE);
    assign rdata          = rdata_q;
    assign err_timeout    = err_to_q;
    assign err_misaligned = err_mis_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_we     = mem_we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: vector table with a
// scoreboard queue, plus timeout, flush and reset-in-WRITE sequences.
module tb_dmem_access_ctrl;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_maddr;
        int          exp_cyc;
        int          exp_we;
        bit          exp_mis;
        bit          exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        err_timeout;
    logic        err_misaligned;
    logic        ready_en = 1'b1;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t vecs[6];

    logic [31:0] mem_arr [64] = '{4: 32'hCAFE0001, default: 32'h0};

    always #5 clk = ~clk;

    dmem_access_ctrl_if bus();

    assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
    assign bus.mem_ready = ready_en;

    always @(posedge clk) begin
        if (bus.mem_we) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    dmem_access_ctrl #(
        .SETTLE_CYCLES (1),
        .TIMEOUT       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .rdata          (rdata),
        .err_timeout    (err_timeout),
        .err_misaligned (err_misaligned),
        .mem            (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] er,
                                logic [31:0] ema, int cyc, int we,
                                bit mis, bit to);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_maddr = ema; v.exp_cyc = cyc;
        v.exp_we = we; v.exp_mis = mis; v.exp_to = to;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int          cyc = 0;
        int          we_n = 0;
        logic [31:0] we_a = '0;
        bit          done = 0;
        vec_t        e;
        req_read  = v.rd;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        sb.push_back(v);
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_n++;
                we_a = bus.mem_addr;
            end
            if (!stall) begin
                done = 1;
                e = sb.pop_front();
                chk("stall_cycles", cyc, e.exp_cyc);
                chk("rdata", rdata, e.exp_rdata);
                chk("we_count", we_n, e.exp_we);
                if (e.exp_we != 0) chk("we_addr", we_a, e.addr);
                chk("mem_addr", bus.mem_addr, e.exp_maddr);
                chk("err_misaligned", 32'(err_misaligned), 32'(e.exp_mis));
                chk("err_timeout", 32'(err_timeout), 32'(e.exp_to));
            end else begin
                cyc++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_bound: got no DONE expected DONE by %0d", v.exp_cyc);
            sb.delete();
        end
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(1, 0, 32'h10, 0, 32'hCAFE0001, 32'h10, 3, 0, 0, 0);
        vecs[1] = mk(0, 1, 32'h20, 32'h12345678, 32'hCAFE0001, 32'h20, 4, 1, 0, 0);
        vecs[2] = mk(1, 0, 32'h20, 0, 32'h12345678, 32'h20, 3, 0, 0, 0);
        vecs[3] = mk(1, 1, 32'h24, 32'hA5A5A5A5, 32'h12345678, 32'h24, 4, 1, 0, 0);
        vecs[4] = mk(1, 0, 32'h24, 0, 32'hA5A5A5A5, 32'h24, 3, 0, 0, 0);
        vecs[5] = mk(1, 0, 32'h13, 0, 32'h0, 32'h24, 1, 0, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_errs", {30'd0, err_timeout, err_misaligned}, 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_txn(vecs[i]);
        chk("mem_word9", mem_arr[9], 32'hA5A5A5A5);

        ready_en = 1'b0;
        run_txn(mk(1, 0, 32'h30, 0, 32'h0, 32'h30, 18, 0, 1, 1));
        ready_en = 1'b1;
        run_txn(mk(1, 0, 32'h10, 0, 32'hCAFE0001, 32'h10, 3, 0, 1, 1));

        // Flush: request dropped while waiting; transaction still completes.
        req_read = 1'b1;
        req_addr = 32'h20;
        @(posedge clk);
        #1;
        req_read = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 0);
        repeat (4) @(negedge clk);
        chk("flush_rdata", rdata, 32'h12345678);
        chk("flush_mem_addr", bus.mem_addr, 32'h20);
        @(posedge clk);
        #1;

        // Reset asserted during the WRITE cycle.
        req_write = 1'b1;
        req_addr  = 32'h28;
        req_wdata = 32'hDEADBEEF;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.mem_we && n < 10);
            chk("rstw_reached_write", 32'(bus.mem_we), 1);
        end
        rst = 1'b1;
        #1;
        chk("rstw_mem_we", 32'(bus.mem_we), 0);
        chk("rstw_mem_addr", bus.mem_addr, 0);
        chk("rstw_mem_wdata", bus.mem_wdata, 0);
        chk("rstw_rdata", rdata, 0);
        chk("rstw_errs", {30'd0, err_timeout, err_misaligned}, 0);
        req_write = 1'b0;
        #1;
        chk("rstw_stall", 32'(stall), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_mem_word10", mem_arr[10], 0);
        @(posedge clk);
        #1;
        run_txn(mk(1, 0, 32'h28, 0, 32'h0, 32'h28, 3, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
